// File: rtl/wave_capture.sv
// Write-side controller for the wave sample buffer: decimates ADC samples into a circular
// record, detects a level-crossing trigger and freezes a pretrigger/posttrigger record.
//
//   state     | meaning
//   S_IDLE    | waiting to start (arm pulse in single mode)
//   S_PREFILL | filling the PRETRIG samples that precede any trigger
//   S_ARMED   | writing and watching for a trigger (or auto timeout)
//   S_POST    | writing the samples that follow the trigger
//   S_DONE    | record frozen until the reader reports frame_done
module wave_capture #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 9,
    parameter int DEPTH        = 1024,
    parameter int PRETRIG      = 256,
    parameter int AUTO_TIMEOUT = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [7:0]        decim,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] wraddr,
    output logic [DATA_W-1:0] wrdata,
    output logic              we,
    output logic [ADDR_W-1:0] start_addr,
    output logic              capture_done,
    output logic              trig_real,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int POST_N = DEPTH - PRETRIG - 1;
    localparam logic [ADDR_W-1:0] PRE_LD   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] POST_LD  = ADDR_W'(POST_N);
    localparam logic [ADDR_W-1:0] PH_ONE   = ADDR_W'(1);
    localparam logic [15:0]       AUTO_LD  = 16'(AUTO_TIMEOUT);
    localparam logic [1:0]        MODE_AUTO   = 2'b01;
    localparam logic [1:0]        MODE_SINGLE = 2'b10;

    state_t              state_q, state_d;
    logic [7:0]          dcnt_q, dcnt_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [15:0]         auto_cnt_q, auto_cnt_d;
    logic                trig_real_q, trig_real_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [1:0]          mode_q, mode_d;

    logic in_capture;
    logic accept;
    logic hit_rise;
    logic hit_fall;
    logic hit_real;
    logic auto_fire;
    logic trig_fire;
    logic pre_last;
    logic post_last;
    logic enter_prefill;
    logic enter_armed;
    logic idle_done_exit;

    always_comb begin
        in_capture = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);
        accept     = in_capture && sample_valid && (dcnt_q >= decim);
        hit_rise   = prev_valid_q && (prev_q < trig_level) && (sample_in >= trig_level);
        hit_fall   = prev_valid_q && (prev_q > trig_level) && (sample_in <= trig_level);
        hit_real   = trig_slope ? hit_fall : hit_rise;
        auto_fire  = (mode_q == MODE_AUTO) && (auto_cnt_q == 16'd1);
        trig_fire  = accept && (state_q == S_ARMED) && (hit_real || auto_fire);
        pre_last   = accept && (state_q == S_PREFILL) && (ph_cnt_q == PH_ONE);
        post_last  = accept && (state_q == S_POST) && (ph_cnt_q == PH_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((mode != MODE_SINGLE) || arm) begin
                    state_d = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (pre_last) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_fire) begin
                    state_d = (POST_N == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (post_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (frame_done) begin
                    state_d = (mode == MODE_SINGLE) ? S_IDLE : S_PREFILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enter_prefill  = (state_q != S_PREFILL) && (state_d == S_PREFILL);
        enter_armed    = (state_q != S_ARMED) && (state_d == S_ARMED);
        idle_done_exit = ((state_q == S_IDLE) || (state_q == S_DONE)) && (state_d != state_q);
        capture_done   = (state_q == S_DONE);
        busy           = in_capture;
        we             = we_q;
        wraddr         = wraddr_q;
        wrdata         = wrdata_q;
        start_addr     = start_q;
        trig_real      = trig_real_q;
    end

    always_comb begin
        dcnt_d       = dcnt_q;
        wp_d         = wp_q;
        we_d         = 1'b0;
        wraddr_d     = wraddr_q;
        wrdata_d     = wrdata_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        ph_cnt_d     = ph_cnt_q;
        auto_cnt_d   = auto_cnt_q;
        trig_real_d  = trig_real_q;
        start_d      = start_q;
        mode_d       = mode_q;

        if (!in_capture) begin
            dcnt_d = 8'd0;
        end else if (sample_valid) begin
            dcnt_d = accept ? 8'd0 : dcnt_q + 8'd1;
        end

        // DEPTH is a power of two, so the natural wrap of wp is the circular wrap.
        if (accept) begin
            we_d         = 1'b1;
            wraddr_d     = wp_q;
            wrdata_d     = sample_in;
            wp_d         = wp_q + PH_ONE;
            prev_d       = sample_in;
            prev_valid_d = 1'b1;
            if (state_q != S_ARMED) begin
                ph_cnt_d = ph_cnt_q - PH_ONE;
            end else if (auto_cnt_q != 16'd0) begin
                auto_cnt_d = auto_cnt_q - 16'd1;
            end
        end

        if (trig_fire) begin
            trig_real_d = hit_real;
            start_d     = wp_q - PRE_LD;
            ph_cnt_d    = POST_LD;
        end

        if (enter_armed) begin
            auto_cnt_d = AUTO_LD;
        end

        if (enter_prefill) begin
            prev_valid_d = 1'b0;
            ph_cnt_d     = PRE_LD;
            trig_real_d  = 1'b0;
        end

        if (idle_done_exit) begin
            mode_d = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q       <= '0;
            wp_q         <= '0;
            we_q         <= 1'b0;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            ph_cnt_q     <= '0;
            auto_cnt_q   <= '0;
            trig_real_q  <= 1'b0;
            start_q      <= '0;
            mode_q       <= '0;
        end else begin
            dcnt_q       <= dcnt_d;
            wp_q         <= wp_d;
            we_q         <= we_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            ph_cnt_q     <= ph_cnt_d;
            auto_cnt_q   <= auto_cnt_d;
            trig_real_q  <= trig_real_d;
            start_q      <= start_d;
            mode_q       <= mode_d;
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: normal/falling/auto/decimated/single-shot captures and
// a reset issued in the middle of the posttrigger phase.
module tb_wave_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] sample_in;
    logic       sample_valid;
    logic [7:0] decim;
    logic [8:0] trig_level;
    logic       trig_slope;
    logic [1:0] mode;
    logic       arm;
    logic       frame_done;
    logic [9:0] wraddr;
    logic [8:0] wrdata;
    logic       we;
    logic [9:0] start_addr;
    logic       capture_done;
    logic       trig_real;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wave_capture dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .decim        (decim),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .mode         (mode),
        .arm          (arm),
        .frame_done   (frame_done),
        .wraddr       (wraddr),
        .wrdata       (wrdata),
        .we           (we),
        .start_addr   (start_addr),
        .capture_done (capture_done),
        .trig_real    (trig_real),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: rising ramp 0..511, kind 1: falling ramp 511..0, otherwise constant 50
    function automatic int sample_val(input int kind, input int idx);
        if (kind == 0) return idx % 512;
        if (kind == 1) return 511 - (idx % 512);
        return 50;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        arm          = 1'b0;
        frame_done   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        chk(tag, int'(busy), 1);
    endtask

    // Feeds one sample per cycle from the first accepted sample until capture_done.
    task automatic run_capture(input string tag, input int kind, input int budget,
                               output int n_wr, output int last_addr, output int errs);
        int idx = 0;
        n_wr      = 0;
        last_addr = -1;
        errs      = 0;
        while (idx < budget) begin
            sample_in    = 9'(sample_val(kind, idx));
            sample_valid = 1'b1;
            tick();
            if (we) begin
                if (int'(wrdata) != sample_val(kind, idx)) errs++;
                if (int'(wraddr) != n_wr % 1024) errs++;
                n_wr++;
                last_addr = int'(wraddr);
            end
            idx++;
            if (capture_done) break;
        end
        sample_valid = 1'b0;
        chk({tag, "_done"}, int'(capture_done), 1);
    endtask

    initial begin
        int n_wr, last_addr, errs, cnt_we, cnt_busy;

        sample_in  = '0;
        decim      = 8'd0;
        trig_level = 9'd100;
        trig_slope = 1'b0;
        mode       = 2'b00;

        // 1: normal mode, rising ramp
        do_reset();
        chk("rst_we", int'(we), 0);
        chk("rst_wraddr", int'(wraddr), 0);
        chk("rst_capture_done", int'(capture_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_trig_real", int'(trig_real), 0);
        chk("rst_start_addr", int'(start_addr), 0);
        wait_busy("t1_busy");
        run_capture("t1", 0, 5000, n_wr, last_addr, errs);
        chk("t1_writes", n_wr, 1380);
        chk("t1_last_addr", last_addr, 355);
        chk("t1_start_addr", int'(start_addr), 356);
        chk("t1_trig_real", int'(trig_real), 1);
        chk("t1_data", errs, 0);
        cnt_we = 0;
        for (int k = 0; k < 20; k++) begin
            sample_in    = 9'(k);
            sample_valid = 1'b1;
            tick();
            if (we) cnt_we++;
        end
        sample_valid = 1'b0;
        chk("t1_hold_no_we", cnt_we, 0);
        chk("t1_hold_done", int'(capture_done), 1);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("t1_rearm_busy", int'(busy), 1);
        chk("t1_rearm_done", int'(capture_done), 0);

        // 2: falling slope, descending ramp
        trig_slope = 1'b1;
        do_reset();
        wait_busy("t2_busy");
        run_capture("t2", 1, 5000, n_wr, last_addr, errs);
        chk("t2_writes", n_wr, 1179);
        chk("t2_last_addr", last_addr, 154);
        chk("t2_start_addr", int'(start_addr), 155);
        chk("t2_trig_real", int'(trig_real), 1);
        chk("t2_data", errs, 0);

        // 3: auto mode, constant input never crosses the level
        trig_slope = 1'b0;
        mode       = 2'b01;
        do_reset();
        wait_busy("t3_busy");
        run_capture("t3", 2, 5000, n_wr, last_addr, errs);
        chk("t3_writes", n_wr, 3023);
        chk("t3_last_addr", last_addr, 974);
        chk("t3_start_addr", int'(start_addr), 975);
        chk("t3_trig_real", int'(trig_real), 0);
        chk("t3_data", errs, 0);

        // 4: decimation by 4
        mode       = 2'b00;
        decim      = 8'd3;
        trig_level = 9'd511;
        do_reset();
        wait_busy("t4_busy");
        for (int k = 0; k < 40; k++) begin
            sample_in    = 9'(k);
            sample_valid = 1'b1;
            tick();
            chk("t4_we", int'(we), (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) chk("t4_wrdata", int'(wrdata), k);
        end
        sample_valid = 1'b0;
        decim        = 8'd0;
        trig_level   = 9'd100;

        // 5: single-shot mode
        mode = 2'b10;
        do_reset();
        cnt_we   = 0;
        cnt_busy = 0;
        for (int k = 0; k < 5000; k++) begin
            sample_in    = 9'(k % 512);
            sample_valid = 1'b1;
            tick();
            if (we) cnt_we++;
            if (busy) cnt_busy++;
        end
        sample_valid = 1'b0;
        chk("t5_idle_we", cnt_we, 0);
        chk("t5_idle_busy", cnt_busy, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_armed_busy", int'(busy), 1);
        run_capture("t5", 0, 5000, n_wr, last_addr, errs);
        chk("t5_last_addr", last_addr, 355);
        chk("t5_start_addr", int'(start_addr), 356);
        chk("t5_trig_real", int'(trig_real), 1);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("t5_idle_again_busy", int'(busy), 0);
        chk("t5_idle_again_done", int'(capture_done), 0);
        cnt_we = 0;
        for (int k = 0; k < 50; k++) begin
            sample_in    = 9'(k);
            sample_valid = 1'b1;
            tick();
            if (we) cnt_we++;
        end
        sample_valid = 1'b0;
        chk("t5_after_frame_we", cnt_we, 0);

        // 6: reset during the posttrigger phase
        mode = 2'b00;
        do_reset();
        wait_busy("t6_busy");
        for (int k = 0; k < 700; k++) begin
            sample_in    = 9'(k % 512);
            sample_valid = 1'b1;
            tick();
        end
        chk("t6_post_busy", int'(busy), 1);
        chk("t6_post_trig_real", int'(trig_real), 1);
        chk("t6_post_done", int'(capture_done), 0);
        rst = 1'b1;
        tick();
        chk("t6_rst_we", int'(we), 0);
        chk("t6_rst_wraddr", int'(wraddr), 0);
        chk("t6_rst_done", int'(capture_done), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_trig_real", int'(trig_real), 0);
        rst          = 1'b0;
        sample_valid = 1'b0;
        wait_busy("t6_restart_busy");
        sample_in    = 9'd77;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("t6_restart_we", int'(we), 1);
        chk("t6_restart_wraddr", int'(wraddr), 0);
        chk("t6_restart_wrdata", int'(wrdata), 77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
